// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one valid/ready word-access memory port.
// Round-robin or fixed-priority selection, non-preemptive, response routed back to the owner.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_valid_i,
    output logic                  m0_ready_o,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,

    input  logic                  m1_valid_i,
    output logic                  m1_ready_o,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,

    output logic                  s_valid_o,
    input  logic                  s_ready_i,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic                  s_we_o,
    output logic [3:0]            s_be_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    input  logic [DATA_WIDTH-1:0] s_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last;       // last completed port; the other port wins a round-robin tie
    logic   granted;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (m0_valid_i && m1_valid_i)
                    next_state = (FIXED_PRIO || last) ? GRANT0 : GRANT1;
                else if (m0_valid_i)
                    next_state = GRANT0;
                else if (m1_valid_i)
                    next_state = GRANT1;
            end
            // The completing master's own valid is not examined here.
            GRANT0: if (s_ready_i) next_state = m1_valid_i ? GRANT1 : IDLE;
            GRANT1: if (s_ready_i) next_state = m0_valid_i ? GRANT0 : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are captured on entry to a grant; masters hold them stable until ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            s_addr_o  <= '0;
            s_we_o    <= 1'b0;
            s_be_o    <= '0;
            s_wdata_o <= '0;
        end else begin
            state <= next_state;
            if (state == GRANT0 && s_ready_i)
                last <= 1'b0;
            else if (state == GRANT1 && s_ready_i)
                last <= 1'b1;

            if (next_state == GRANT0 && state != GRANT0) begin
                s_addr_o  <= m0_addr_i;
                s_we_o    <= m0_we_i;
                s_be_o    <= m0_be_i;
                s_wdata_o <= m0_wdata_i;
            end else if (next_state == GRANT1 && state != GRANT1) begin
                s_addr_o  <= m1_addr_i;
                s_we_o    <= m1_we_i;
                s_be_o    <= m1_be_i;
                s_wdata_o <= m1_wdata_i;
            end else if (next_state == IDLE) begin
                s_addr_o  <= '0;
                s_we_o    <= 1'b0;
                s_be_o    <= '0;
                s_wdata_o <= '0;
            end
        end
    end

    // Valid drops in the completion cycle so a re-sampling slave never sees a duplicate.
    assign granted    = (state == GRANT0) || (state == GRANT1);
    assign s_valid_o  = granted && !s_ready_i;

    assign m0_ready_o = (state == GRANT0) && s_ready_i;
    assign m1_ready_o = (state == GRANT1) && s_ready_i;
    assign m0_rdata_o = m0_ready_o ? s_rdata_i : '0;
    assign m1_rdata_o = m1_ready_o ? s_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: round-robin instance with a
// variable-latency memory model, plus a fixed-priority instance with a 1-cycle model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [3:0]  m0_be = 4'hF, m1_be = 4'hF;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_ready, s_we;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        s_ready_m;
    logic        inject_ready = 1'b0;

    logic        p_m0_valid = 1'b0, p_m1_valid = 1'b0;
    logic        p_m0_ready, p_m1_ready;
    logic [31:0] p_m0_addr = '0, p_m1_addr = '0;
    logic [31:0] p_m0_rdata, p_m1_rdata;
    logic        p_s_valid, p_s_ready, p_s_we;
    logic [31:0] p_s_addr, p_s_wdata, p_s_rdata;
    logic [3:0]  p_s_be;

    logic [31:0] mem [16];
    int          mem_lat = 1;
    int          mcnt;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign s_ready = s_ready_m | inject_ready;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
        .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_rdata_o(m0_rdata),
        .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
        .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_rdata_o(m1_rdata),
        .s_valid_o(s_valid), .s_ready_i(s_ready), .s_addr_o(s_addr), .s_we_o(s_we),
        .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rdata_i(s_rdata)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_valid_i(p_m0_valid), .m0_ready_o(p_m0_ready), .m0_addr_i(p_m0_addr), .m0_we_i(1'b0),
        .m0_be_i(4'hF), .m0_wdata_i(32'h0), .m0_rdata_o(p_m0_rdata),
        .m1_valid_i(p_m1_valid), .m1_ready_o(p_m1_ready), .m1_addr_i(p_m1_addr), .m1_we_i(1'b0),
        .m1_be_i(4'hF), .m1_wdata_i(32'h0), .m1_rdata_o(p_m1_rdata),
        .s_valid_o(p_s_valid), .s_ready_i(p_s_ready), .s_addr_o(p_s_addr), .s_we_o(p_s_we),
        .s_be_o(p_s_be), .s_wdata_o(p_s_wdata), .s_rdata_i(p_s_rdata)
    );

    // Memory model: completes after mem_lat cycles of valid, registered ready/rdata.
    always @(posedge clk) begin
        s_ready_m <= 1'b0;
        if (rst) begin
            mcnt <= 0;
            for (int i = 0; i < 16; i++)
                mem[i] <= (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0000 + 32'(i);
        end else if (s_valid) begin
            if (mcnt == mem_lat - 1) begin
                s_ready_m <= 1'b1;
                s_rdata   <= mem[s_addr[5:2]];
                if (s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_be[b]) mem[s_addr[5:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    always @(posedge clk) begin
        p_s_ready <= p_s_valid && !rst;
        p_s_rdata <= {16'hB0B0, p_s_addr[15:0]};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; m0_valid = 1'b1; m1_valid = 1'b1;
        m0_addr = 32'h10; m1_addr = 32'h24;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_s_valid: got %b expected 0", s_valid); end
            checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL reset_m0_ready: got %b expected 0", m0_ready); end
            checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL reset_m1_ready: got %b expected 0", m1_ready); end
        end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_s_addr: got %h expected 0", s_addr); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL reset_m0_rdata: got %h expected 0", m0_rdata); end
        rst = 1'b0;
        step();
        checks++; if ({s_valid, s_addr} !== {1'b1, 32'h10}) begin errors++; $display("FAIL reset_first_grant: got valid=%b addr=%h expected valid=1 addr=00000010", s_valid, s_addr); end
        step();
        checks++; if ({m0_ready, m0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL reset_m0_done: got %b/%h expected 1/deadbeef", m0_ready, m0_rdata); end
        m0_valid = 1'b0;
        step();
        checks++; if ({s_valid, s_addr} !== {1'b1, 32'h24}) begin errors++; $display("FAIL reset_m1_grant: got %b/%h expected 1/00000024", s_valid, s_addr); end
        step();
        checks++; if ({m1_ready, m1_rdata} !== {1'b1, 32'hA000_0009}) begin errors++; $display("FAIL reset_m1_done: got %b/%h expected 1/a0000009", m1_ready, m1_rdata); end
        m1_valid = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", s_valid); end
    endtask

    task automatic test_round_robin;
        int order [16];
        int ccyc [16];
        int ncomp = 0, n0 = 0, n1 = 0;
        m0_addr = 32'h00; m1_addr = 32'h20;
        m0_valid = 1'b1; m1_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && ncomp < 8; cyc++) begin
            step();
            checks++; if (s_valid && s_ready) begin errors++; $display("FAIL rr_valid_with_ready: got valid=1 ready=1 expected valid=0 at cycle %0d", cyc); end
            checks++; if (m0_ready && m1_ready) begin errors++; $display("FAIL rr_both_ready: got 11 expected at most one at cycle %0d", cyc); end
            if (m0_ready && ncomp < 16) begin
                order[ncomp] = 0; ccyc[ncomp] = cyc; ncomp++;
                checks++; if (m0_rdata !== 32'hA000_0000 + (m0_addr >> 2)) begin errors++; $display("FAIL rr_m0_rdata: got %h expected %h", m0_rdata, 32'hA000_0000 + (m0_addr >> 2)); end
                n0++;
                if (n0 == 4) m0_valid = 1'b0; else m0_addr = m0_addr + 32'h4;
            end
            if (m1_ready && ncomp < 16) begin
                order[ncomp] = 1; ccyc[ncomp] = cyc; ncomp++;
                checks++; if (m1_rdata !== 32'hA000_0000 + (m1_addr >> 2)) begin errors++; $display("FAIL rr_m1_rdata: got %h expected %h", m1_rdata, 32'hA000_0000 + (m1_addr >> 2)); end
                n1++;
                if (n1 == 4) m1_valid = 1'b0; else m1_addr = m1_addr + 32'h4;
            end
        end
        checks++; if (ncomp != 8) begin errors++; $display("FAIL rr_completions: got %0d expected 8", ncomp); end
        for (int i = 0; i < 8 && i < ncomp; i++) begin
            checks++; if (order[i] != i % 2) begin errors++; $display("FAIL rr_order[%0d]: got port %0d expected port %0d", i, order[i], i % 2); end
        end
        for (int i = 1; i < 8 && i < ncomp; i++) begin
            checks++; if (ccyc[i] - ccyc[i-1] != 2) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 2", i, ccyc[i] - ccyc[i-1]); end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        step();
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rr_idle: got %b expected 0", s_valid); end
    endtask

    task automatic test_single_read;
        m0_addr = 32'h10; m0_we = 1'b0; m0_valid = 1'b1;
        step();
        checks++; if ({s_valid, s_we, s_addr} !== {1'b1, 1'b0, 32'h10}) begin errors++; $display("FAIL read_req: got valid=%b we=%b addr=%h expected 1/0/00000010", s_valid, s_we, s_addr); end
        checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL read_m1_quiet1: got %b expected 0", m1_ready); end
        step();
        checks++; if ({m0_ready, m0_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin errors++; $display("FAIL read_m0_done: got %b/%h expected 1/deadbeef", m0_ready, m0_rdata); end
        checks++; if ({m1_ready, m1_rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL read_m1_quiet2: got %b/%h expected 0/00000000", m1_ready, m1_rdata); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL read_valid_drop: got %b expected 0", s_valid); end
        m0_valid = 1'b0;
        step();
        checks++; if ({m0_ready, s_valid} !== 2'b00) begin errors++; $display("FAIL read_after: got ready=%b valid=%b expected 00", m0_ready, s_valid); end
    endtask

    task automatic test_single_stream;
        int ccyc [4];
        int n = 0;
        m0_addr = 32'h04; m0_valid = 1'b1;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            step();
            if (m0_ready) begin
                ccyc[n] = cyc; n++;
                if (n == 3) m0_valid = 1'b0;
            end
        end
        checks++; if (n != 3) begin errors++; $display("FAIL stream_completions: got %0d expected 3", n); end
        for (int i = 1; i < 3 && i < n; i++) begin
            checks++; if (ccyc[i] - ccyc[i-1] != 3) begin errors++; $display("FAIL stream_spacing[%0d]: got %0d cycles expected 3", i, ccyc[i] - ccyc[i-1]); end
        end
        m0_valid = 1'b0;
        step();
    endtask

    task automatic test_write;
        int nvalid = 0, nready = 0, nm0 = 0;
        bit done = 0;
        mem_lat = 3;
        m1_addr = 32'h20; m1_we = 1'b1; m1_be = 4'b0011; m1_wdata = 32'h1234_5678;
        m1_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            step();
            if (m1_ready) nready++;
            if (m0_ready) nm0++;
            if (!done) begin
                if (s_valid) begin
                    nvalid++;
                    checks++;
                    if ({s_we, s_be, s_wdata, s_addr} !== {1'b1, 4'b0011, 32'h1234_5678, 32'h20}) begin
                        errors++;
                        $display("FAIL write_fields: got we=%b be=%b wdata=%h addr=%h expected 1/0011/12345678/00000020", s_we, s_be, s_wdata, s_addr);
                    end
                end
                if (m1_ready) begin
                    done = 1;
                    m1_valid = 1'b0; m1_we = 1'b0; m1_be = 4'hF;
                end
            end
        end
        checks++; if (nvalid != 3) begin errors++; $display("FAIL write_valid_cycles: got %0d expected 3", nvalid); end
        checks++; if (nready != 1) begin errors++; $display("FAIL write_ready_pulses: got %0d expected 1", nready); end
        checks++; if (nm0 != 0) begin errors++; $display("FAIL write_m0_quiet: got %0d pulses expected 0", nm0); end
        checks++; if (mem[8] !== 32'hA000_5678) begin errors++; $display("FAIL write_mem: got %h expected a0005678", mem[8]); end
        mem_lat = 1;
    endtask

    task automatic test_reset_mid_grant;
        int nm0 = 0;
        mem_lat = 3;
        m0_addr = 32'h10; m0_valid = 1'b1;
        step();
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL abort_grant: got %b expected 1", s_valid); end
        step();
        if (m0_ready) nm0++;
        rst = 1'b1; m0_valid = 1'b0;
        step();
        if (m0_ready) nm0++;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL abort_valid_drop: got %b expected 0", s_valid); end
        rst = 1'b0;
        step();
        if (m0_ready) nm0++;
        inject_ready = 1'b1;
        #1;
        checks++; if ({m0_ready, m1_ready, s_valid} !== 3'b000) begin errors++; $display("FAIL abort_late_ready: got m0=%b m1=%b valid=%b expected 000", m0_ready, m1_ready, s_valid); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL abort_rdata: got %h expected 0", m0_rdata); end
        step();
        inject_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (m0_ready) nm0++;
        end
        checks++; if (nm0 != 0) begin errors++; $display("FAIL abort_m0_pulses: got %0d expected 0", nm0); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b expected 0", s_valid); end
        mem_lat = 1;
    endtask

    task automatic test_fixed_prio;
        // Serve port 0 alone first so round-robin would favour port 1 on the next tie.
        p_m0_addr = 32'h04; p_m0_valid = 1'b1;
        step();
        step();
        checks++; if ({p_m0_ready, p_m0_rdata} !== {1'b1, 32'hB0B0_0004}) begin errors++; $display("FAIL fp_solo: got %b/%h expected 1/b0b00004", p_m0_ready, p_m0_rdata); end
        p_m0_valid = 1'b0;
        step();
        p_m0_addr = 32'h08; p_m1_addr = 32'h0C;
        p_m0_valid = 1'b1; p_m1_valid = 1'b1;
        step();
        checks++; if ({p_s_valid, p_s_addr} !== {1'b1, 32'h08}) begin errors++; $display("FAIL fp_tie_grant: got %b/%h expected 1/00000008", p_s_valid, p_s_addr); end
        step();
        checks++; if ({p_m0_ready, p_m1_ready, p_m0_rdata} !== {2'b10, 32'hB0B0_0008}) begin errors++; $display("FAIL fp_m0_done: got %b%b/%h expected 10/b0b00008", p_m0_ready, p_m1_ready, p_m0_rdata); end
        p_m0_valid = 1'b0;
        step();
        checks++; if ({p_s_valid, p_s_addr} !== {1'b1, 32'h0C}) begin errors++; $display("FAIL fp_handoff: got %b/%h expected 1/0000000c", p_s_valid, p_s_addr); end
        step();
        checks++; if ({p_m1_ready, p_m1_rdata} !== {1'b1, 32'hB0B0_000C}) begin errors++; $display("FAIL fp_m1_done: got %b/%h expected 1/b0b0000c", p_m1_ready, p_m1_rdata); end
        p_m1_valid = 1'b0;
        step();
        checks++; if (p_s_valid !== 1'b0) begin errors++; $display("FAIL fp_idle: got %b expected 0", p_s_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_single_stream();
        test_write();
        test_reset_mid_grant();
        test_fixed_prio();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
